// File: rtl/lsu_align_ctrl.sv
// lsu_align_ctrl: load/store alignment unit between the core and a
// handshaked word-wide data-memory port. One request at a time; misaligned
// accesses become two word transactions (SPLIT_EN=1) or an error (SPLIT_EN=0).
// Load data is reassembled from the lanes and then sign- or zero-extended.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ls_valid/ls_ready     core request handshake (ready only when idle)
//   ls_we, ls_type        store flag, one-hot size/sign code
//   ls_addr, ls_wdata     byte address, right-aligned store data
//   ls_done/ls_rdata/ls_err  one-cycle completion with result and error flag
//   mem_req/mem_gnt       bus request handshake
//   mem_we/mem_addr/mem_be/mem_wdata  word-aligned access, byte enables, lane data
//   mem_rvalid/mem_rdata  read data / write acknowledge
module lsu_align_ctrl #(
    parameter int unsigned ADDR_W   = 32,
    parameter bit          SPLIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ls_valid,
    output logic              ls_ready,
    input  logic              ls_we,
    input  logic [4:0]        ls_type,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    output logic              ls_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [4:0] T_B  = 5'b10000;
    localparam logic [4:0] T_H  = 5'b01000;
    localparam logic [4:0] T_W  = 5'b00100;
    localparam logic [4:0] T_BU = 5'b00010;
    localparam logic [4:0] T_HU = 5'b00001;

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
    state_t state, state_nx;

    logic              we_q;
    logic [4:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q;

    // Request fields come straight from the core while idle so the first
    // bus word can be registered in the accept cycle; afterwards the latched
    // copy drives the same lane logic.
    logic              src_we;
    logic [4:0]        src_type;
    logic [ADDR_W-1:0] src_addr;
    logic [31:0]       src_wdata;

    always_comb begin
        if (state == IDLE) begin
            src_we    = ls_we;
            src_type  = ls_type;
            src_addr  = ls_addr;
            src_wdata = ls_wdata;
        end else begin
            src_we    = we_q;
            src_type  = type_q;
            src_addr  = addr_q;
            src_wdata = wdata_q;
        end
    end

    logic [1:0]        off;
    logic [3:0]        nbytes;
    logic [3:0]        mask4;
    logic [31:0]       wmask;
    logic              type_ok;
    logic              split;
    logic              bad;
    logic [7:0]        be8;
    logic [63:0]       wd64;
    logic [ADDR_W-1:0] w0_addr;
    logic [ADDR_W-1:0] w1_addr;

    always_comb begin
        off     = src_addr[1:0];
        type_ok = 1'b1;
        nbytes  = 4'd4;
        mask4   = 4'b1111;
        wmask   = '1;
        case (src_type)
            T_B, T_BU: begin
                nbytes = 4'd1;
                mask4  = 4'b0001;
                wmask  = 32'h0000_00ff;
            end
            T_H, T_HU: begin
                nbytes = 4'd2;
                mask4  = 4'b0011;
                wmask  = 32'h0000_ffff;
            end
            T_W:     ;
            default: type_ok = 1'b0;
        endcase
        split   = ({2'b00, off} + nbytes) > 4'd4;
        bad     = !type_ok || (src_we && (src_type == T_BU || src_type == T_HU))
                  || (split && !SPLIT_EN);
        be8     = {4'b0000, mask4} << off;
        // Store data is masked to its size so disabled lanes stay zero.
        wd64    = {32'h0, src_wdata & wmask} << {off, 3'b000};
        w0_addr = {src_addr[ADDR_W-1:2], 2'b00};
        w1_addr = w0_addr + ADDR_W'(4);
    end

    // Load result; the arriving beat is used directly so the answer is
    // ready to register on the transition into RESP.
    logic [31:0] rd_lo;
    logic [31:0] rd_hi;
    logic [31:0] r;
    logic [31:0] ext;
    logic [31:0] rdata_c;

    always_comb begin
        rd_lo = (state == WAIT0) ? mem_rdata : lo_q;
        rd_hi = (state == WAIT1) ? mem_rdata : '0;
        r     = 32'({rd_hi, rd_lo} >> {off, 3'b000});
        case (src_type)
            T_B:     ext = {{24{r[7]}}, r[7:0]};
            T_H:     ext = {{16{r[15]}}, r[15:0]};
            T_W:     ext = r;
            T_BU:    ext = {24'h0, r[7:0]};
            T_HU:    ext = {16'h0, r[15:0]};
            default: ext = '0;
        endcase
        rdata_c = (state == IDLE || src_we) ? '0 : ext;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (ls_valid) state_nx = bad ? RESP : REQ0;
            REQ0:  if (mem_gnt) state_nx = WAIT0;
            WAIT0: if (mem_rvalid) state_nx = split ? REQ1 : RESP;
            REQ1:  if (mem_gnt) state_nx = WAIT1;
            WAIT1: if (mem_rvalid) state_nx = RESP;
            RESP:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ls_ready  <= 1'b1;
            ls_done   <= 1'b0;
            ls_rdata  <= '0;
            ls_err    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            we_q      <= 1'b0;
            type_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lo_q      <= '0;
        end else begin
            ls_ready <= (state_nx == IDLE);
            ls_done  <= (state_nx == RESP);
            mem_req  <= (state_nx == REQ0) || (state_nx == REQ1);
            if (state == IDLE && ls_valid) begin
                we_q    <= ls_we;
                type_q  <= ls_type;
                addr_q  <= ls_addr;
                wdata_q <= ls_wdata;
            end
            if (state == IDLE && state_nx == REQ0) begin
                mem_we    <= src_we;
                mem_addr  <= w0_addr;
                mem_be    <= be8[3:0];
                mem_wdata <= wd64[31:0];
            end
            if (state == WAIT0 && state_nx == REQ1) begin
                mem_addr  <= w1_addr;
                mem_be    <= be8[7:4];
                mem_wdata <= wd64[63:32];
            end
            if (state == WAIT0 && mem_rvalid) lo_q <= mem_rdata;
            if (state_nx == RESP) begin
                ls_err   <= (state == IDLE);
                ls_rdata <= rdata_c;
            end
        end
    end

endmodule
